// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transceiver bus of uart_tx_arbiter.
// slave is the arbiter side, master is the requesters/transceiver side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy;
  logic              locked;
  logic              lock_timeout;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_wr, locked, lock_timeout
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_wr, locked, lock_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-byte round-robin sharing of one UART transmitter between NREQ requesters.
// Define UART_TX_ARB_LOCK_EN to keep a requester granted until it marks the last byte of its frame.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_wr_q, tx_wr_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic [NREQ-1:0] cand;
  logic            found_hi, found_lo, fire;
  logic [PW-1:0]   sel_hi, sel_lo, sel;

  // Lowest candidate above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        if (PW'(i) > ptr_q) begin
          found_hi = 1'b1;
          sel_hi   = PW'(i);
        end else begin
          found_lo = 1'b1;
          sel_lo   = PW'(i);
        end
      end
    end
    sel  = found_hi ? sel_hi : sel_lo;
    fire = (state_q == IDLE) && !bus.tx_busy && (found_hi || found_lo);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    ready_d   = '0;
    grant_d   = grant_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          tx_data_d = bus.req_data[{sel, 3'b000} +: 8];
          tx_wr_d   = 1'b1;
          ready_d   = NREQ'(1) << sel;
          grant_d   = NREQ'(1) << sel;
          ptr_d     = sel;
          state_d   = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NREQ - 1);
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      ready_q   <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_wr     = tx_wr_q;
  assign bus.req_ready = ready_q;
  assign bus.grant     = grant_q;

`ifdef UART_TX_ARB_LOCK_EN
  logic        locked_q, locked_d;
  logic        lock_to_q, lock_to_d;
  logic [15:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;

  // While locked, grant_q still holds the owner, so it doubles as the candidate mask.
  assign cand         = locked_q ? (bus.req_valid & grant_q) : bus.req_valid;
  assign lock_cnt_inc = lock_cnt_q + 16'd1;

  always_comb begin
    locked_d   = locked_q;
    lock_to_d  = 1'b0;
    lock_cnt_d = lock_cnt_q;
    if (fire) begin
      locked_d   = !bus.req_last[sel];
      lock_cnt_d = '0;
    end else if ((state_q == IDLE) && locked_q && !(|(bus.req_valid & grant_q))) begin
      if (lock_cnt_inc == 16'(LOCK_TIMEOUT)) begin
        locked_d   = 1'b0;
        lock_to_d  = 1'b1;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q   <= 1'b0;
      lock_to_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_to_q  <= lock_to_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.lock_timeout = lock_to_q;
`else
  assign cand             = bus.req_valid;
  assign bus.locked       = 1'b0;
  assign bus.lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transceiver busy model.
// Lock scenarios are exercised when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_total  = 0;
  int busy_len = 4;
  int busy_cnt = 0;
  int wr_count = 0;
  int to_count = 0;
  bit ext_busy = 1'b0;

  assign bus.tx_busy = (busy_cnt != 0) || ext_busy;

  // Transceiver model: goes busy for busy_len cycles after each write; its reset clears busy.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else if (bus.tx_wr) begin
      busy_cnt = busy_len;
      wr_count++;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
    if (bus.lock_timeout) to_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      tick();
      cyc++;
      if (bus.tx_wr) ok = 1'b1;
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (bus.tx_busy && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    reset = 1'b1;
    repeat (2) tick();
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.grant); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
    n_total++; if (bus.tx_wr !== 1'b0) $display("FAIL reset_tx_wr: got %b want 0", bus.tx_wr); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus.locked); else n_pass++;
    n_total++; if (bus.lock_timeout !== 1'b0) $display("FAIL reset_lock_timeout: got %b want 0", bus.lock_timeout); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int cyc, base;
    busy_len = 160;
    base = wr_count;
    bus.req_data[7:0] = 8'h55;
    bus.req_last      = 4'b0001;
    bus.req_valid     = 4'b0001;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || cyc != 1) $display("FAIL single_latency: got ok=%0d cyc=%0d want cyc=1", ok, cyc); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", bus.req_ready); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h55) $display("FAIL single_data: got %h want 55", bus.tx_data); else n_pass++;
    bus.req_valid      = 4'b0010;
    bus.req_data[15:8] = 8'h66;
    bus.req_last       = 4'b0010;
    cyc = 0;
    while (bus.tx_busy && cyc < 400) begin
      tick();
      cyc++;
    end
    n_total++; if (wr_count - base != 1) $display("FAIL single_one_write: got %0d writes want 1", wr_count - base); else n_pass++;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || cyc != 2) $display("FAIL single_next_after_busy: got ok=%0d cyc=%0d want cyc=2", ok, cyc); else n_pass++;
    n_total++; if (bus.grant !== 4'b0010) $display("FAIL single_next_grant: got %b want 0010", bus.grant); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h66) $display("FAIL single_next_data: got %h want 66", bus.tx_data); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_contention();
    bit ok;
    int cyc;
    logic [7:0] exp_d;
    logic [3:0] exp_r;
    do_reset();
    busy_len      = 4;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_d = 8'hA0 + 8'(k % 4);
      exp_r = 4'b0001 << (k % 4);
      wait_wr(30, ok, cyc);
      n_total++; if (!ok || bus.tx_data !== exp_d) $display("FAIL rr_data[%0d]: got %h ok=%0d want %h", k, bus.tx_data, ok, exp_d); else n_pass++;
      n_total++; if (bus.req_ready !== exp_r) $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, exp_r); else n_pass++;
    end
    n_total++; if (bus.locked !== 1'b0) $display("FAIL rr_locked: got %b want 0", bus.locked); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_busy_start();
    bit ok;
    int cyc, base;
    ext_busy = 1'b1;
    do_reset();
    busy_len = 4;
    bus.req_data[23:16] = 8'h3C;
    bus.req_last        = 4'b0100;
    bus.req_valid       = 4'b0100;
    base = wr_count;
    repeat (20) tick();
    n_total++; if (wr_count != base) $display("FAIL busy_start_no_wr: got %0d writes want 0", wr_count - base); else n_pass++;
    ext_busy = 1'b0;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || cyc != 1) $display("FAIL busy_start_latency: got ok=%0d cyc=%0d want cyc=1", ok, cyc); else n_pass++;
    n_total++; if (bus.grant !== 4'b0100) $display("FAIL busy_start_grant: got %b want 0100", bus.grant); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h3C) $display("FAIL busy_start_data: got %h want 3c", bus.tx_data); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc, base;
    do_reset();
    busy_len      = 40;
    bus.req_data  = {8'h00, 8'h00, 8'h22, 8'h11};
    bus.req_last  = 4'b0011;
    bus.req_valid = 4'b0001;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || bus.tx_data !== 8'h11) $display("FAIL rmid_first: got %h ok=%0d want 11", bus.tx_data, ok); else n_pass++;
    bus.req_valid = 4'b0010;
    repeat (10) tick();
    base = wr_count;
    #2 reset = 1'b1;
    #1;
    n_total++; if (bus.grant !== 4'b0000) $display("FAIL rmid_async_grant: got %b want 0000", bus.grant); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h00) $display("FAIL rmid_async_data: got %h want 00", bus.tx_data); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b0000 || bus.tx_wr !== 1'b0) $display("FAIL rmid_async_strobes: got ready=%b wr=%b want 0000/0", bus.req_ready, bus.tx_wr); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || cyc != 1) $display("FAIL rmid_resume_latency: got ok=%0d cyc=%0d want cyc=1", ok, cyc); else n_pass++;
    n_total++; if (bus.grant !== 4'b0010 || bus.tx_data !== 8'h22) $display("FAIL rmid_resume: got grant=%b data=%h want 0010/22", bus.grant, bus.tx_data); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
    n_total++; if (wr_count - base != 1) $display("FAIL rmid_once: got %0d writes want 1", wr_count - base); else n_pass++;
  endtask

`ifdef UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    bit ok;
    int cyc;
    do_reset();
    busy_len           = 4;
    bus.req_data[15:8] = 8'hB0;
    bus.req_last       = 4'b0000;
    bus.req_valid      = 4'b0010;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || bus.grant !== 4'b0010 || bus.locked !== 1'b1) $display("FAIL lock_b0: got ok=%0d grant=%b locked=%b want 0010/1", ok, bus.grant, bus.locked); else n_pass++;
    bus.req_data[15:8] = 8'hB1;
    bus.req_data[7:0]  = 8'hC0;
    bus.req_last       = 4'b0001;
    bus.req_valid      = 4'b0011;
    wait_wr(30, ok, cyc);
    n_total++; if (!ok || bus.grant !== 4'b0010 || bus.tx_data !== 8'hB1) $display("FAIL lock_b1: got ok=%0d grant=%b data=%h want 0010/b1", ok, bus.grant, bus.tx_data); else n_pass++;
    n_total++; if (bus.locked !== 1'b1) $display("FAIL lock_held: got %b want 1", bus.locked); else n_pass++;
    bus.req_data[15:8] = 8'hB2;
    bus.req_last       = 4'b0011;
    wait_wr(30, ok, cyc);
    n_total++; if (!ok || bus.grant !== 4'b0010 || bus.tx_data !== 8'hB2) $display("FAIL lock_b2: got ok=%0d grant=%b data=%h want 0010/b2", ok, bus.grant, bus.tx_data); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL lock_release: got %b want 0", bus.locked); else n_pass++;
    bus.req_valid = 4'b0001;
    wait_wr(30, ok, cyc);
    n_total++; if (!ok || bus.grant !== 4'b0001 || bus.tx_data !== 8'hC0) $display("FAIL lock_next: got ok=%0d grant=%b data=%h want 0001/c0", ok, bus.grant, bus.tx_data); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int cyc, n, base;
    do_reset();
    busy_len            = 4;
    bus.req_data[31:24] = 8'hD3;
    bus.req_last        = 4'b0000;
    bus.req_valid       = 4'b1000;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || bus.grant !== 4'b1000 || bus.locked !== 1'b1) $display("FAIL lto_first: got ok=%0d grant=%b locked=%b want 1000/1", ok, bus.grant, bus.locked); else n_pass++;
    base              = to_count;
    bus.req_data[7:0] = 8'hE0;
    bus.req_last      = 4'b0001;
    bus.req_valid     = 4'b0001;
    cyc = 0;
    while (bus.tx_busy && cyc < 100) begin
      tick();
      cyc++;
    end
    n = 0;
    while (!bus.lock_timeout && n < 40) begin
      tick();
      n++;
    end
    n_total++; if (n != 11) $display("FAIL lto_delay: got %0d cycles after busy fell want 11", n); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL lto_unlocked: got %b want 0", bus.locked); else n_pass++;
    wait_wr(10, ok, cyc);
    n_total++; if (!ok || cyc != 1 || bus.grant !== 4'b0001 || bus.tx_data !== 8'hE0) $display("FAIL lto_next: got ok=%0d cyc=%0d grant=%b data=%h want 1/0001/e0", ok, cyc, bus.grant, bus.tx_data); else n_pass++;
    bus.req_valid = '0;
    wait_quiet();
    n_total++; if (to_count - base != 1) $display("FAIL lto_pulses: got %0d want 1", to_count - base); else n_pass++;
  endtask
`else
  task automatic test_no_lock();
    bit ok;
    int cyc;
    logic [3:0] exp_g;
    do_reset();
    busy_len      = 4;
    bus.req_data  = {8'h00, 8'h00, 8'h41, 8'h40};
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      wait_wr(30, ok, cyc);
      n_total++; if (!ok || bus.grant !== exp_g || bus.locked !== 1'b0) $display("FAIL nolock[%0d]: got ok=%0d grant=%b locked=%b want %b/0", k, ok, bus.grant, bus.locked, exp_g); else n_pass++;
    end
    bus.req_valid = '0;
    wait_quiet();
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_busy_start();
    test_reset_mid();
`ifdef UART_TX_ARB_LOCK_EN
    test_lock();
    test_lock_timeout();
`else
    test_no_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmitter of the UART transceiver between `NREQ` on-chip requesters (debug console, status reporter, bridge replies, ...). Per byte, a round-robin arbiter picks one requester, drives `tx_data`/`tx_wr` into the transceiver, and tracks `tx_busy` through the whole character. Optional frame locking keeps one requester granted until it marks its last byte.

## Interface
Parameters:
- `NREQ`, 4, number of requesters, 2..8
- `LOCK_TIMEOUT`, 65535, idle cycles before a held lock is forcibly released, 1..65535, 16-bit counter

Ports:
- `clk`  in  1  system clock, same clock as the transceiver
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  requester i has a byte pending
- `req_data`  in  8*NREQ  byte of requester i at bits [8i+7:8i]
- `req_last`  in  NREQ  byte of requester i is the last of its frame
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse
- `grant`  out  NREQ  one-hot, current or most recent owner; 0 when none
- `tx_data`  out  8  to transceiver `tx_data`
- `tx_wr`  out  1  to transceiver `tx_wr`, single-cycle pulse
- `tx_busy`  in  1  from transceiver `tx_busy`
- `locked`  out  1  frame lock held (constant 0 without the macro)
- `lock_timeout`  out  1  one-cycle pulse when a lock is released by timeout

## Operation
- Reset values: `req_ready`=0, `grant`=0, `tx_data`=0, `tx_wr`=0, `locked`=0, `lock_timeout`=0. State IDLE, round-robin pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if `tx_busy`=0 and a candidate exists, select the first valid requester scanning from pointer+1 upward and wrapping modulo NREQ. On that edge, register `tx_data`=req_data[sel], `req_ready`=onehot(sel), `grant`=onehot(sel) and `tx_wr`=1. Update the pointer to sel, then go to ISSUE. While `tx_busy`=1, IDLE waits, for example after reset or on a foreign write.
- ISSUE: lasts one cycle; `tx_wr` and `req_ready` are high only here. Go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE. Because `tx_busy` is sampled high in the same cycle `tx_wr` drops, this is normally one cycle.
- WAIT_DONE: wait for `tx_busy`=0, then go to IDLE.
- Handshake: the requester holds `req_valid`/`req_data`/`req_last` stable until it sees `req_ready` high. The byte is consumed in the `req_ready` cycle. The requester may present new data the next cycle.
- `req_valid` deasserted before acceptance withdraws the request without error. Selection uses only the values sampled at the IDLE edge.
- Candidates in IDLE:
  - Unlocked: all `req_valid` bits.
  - Locked: only the owner; other requesters are starved until release.

## Timing
- Accept latency: `req_ready` appears 1 cycle after a valid request is sampled in IDLE with `tx_busy`=0.
- `tx_wr` rises in the same cycle as `req_ready`. `tx_data` is stable from that cycle until the next grant.
- Per-byte overhead beyond the transceiver's character time is 2 cycles (ISSUE, WAIT_BUSY) plus 1 IDLE cycle.
- Simultaneous requests are resolved strictly round-robin. With all NREQ requesters valid, the grant order is 0,1,…,NREQ-1,0.
- Asynchronous reset mid-character: the FSM returns to IDLE and `tx_wr` drops immediately. The transceiver's own reset clears `tx_busy`, and nothing is re-sent.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined: frame locking is enabled.
  - Accepting a byte with `req_last[sel]`=0 sets `locked`=1 with owner sel.
  - Accepting a byte with `req_last`=1 clears `locked` on the same edge.
  - While locked in IDLE, a 16-bit counter increments each cycle the owner's `req_valid`=0, and resets to 0 on any owner byte.
  - When the counter reaches `LOCK_TIMEOUT`, `locked` clears and `lock_timeout` pulses for 1 cycle. The pointer is unchanged.
- Not defined: `req_last` is ignored, `locked` and `lock_timeout` are tied to 0, and arbitration happens per byte. No lock counter is built.

## Test plan
- Single requester: req 0 sends 0x55 with `tx_busy` modelled as 1 for 160 cycles after `tx_wr` -> exactly one `tx_wr` with `tx_data`=0x55, `req_ready`=0001 one cycle after valid, and the next grant is not earlier than the cycle after `tx_busy` falls.
- Contention: requesters 0–3 all valid with bytes 0xA0–0xA3, held for 8 bytes -> `tx_data` sequence A0,A1,A2,A3,A0,…, and each `req_ready` is one-hot.
- Busy at start: `tx_busy`=1 held 20 cycles after reset with req 2 valid -> no `tx_wr` until `tx_busy`=0, then `grant`=0100.
- Lock (macro on): req 1 sends 3 bytes with `req_last`=0,0,1 while req 0 is continuously valid -> the three req 1 bytes are contiguous, `locked` falls on the third, and req 0 is granted next.
- Lock timeout (macro on, `LOCK_TIMEOUT`=10): req 3 sends one byte with `req_last`=0, then drops valid -> `lock_timeout` pulses once, 10 idle cycles after return to IDLE, and then req 0 is served.
- Reset in WAIT_DONE: assert `reset` for 2 cycles mid-character -> all outputs are 0 asynchronously, and the pending byte of the next requester is transmitted once after release.
